cdb_arbiter: RTL and testbench

- Responder side of the common-data-bus handshake: functional units (memory unit, adders, multipliers) raise requireCDB with a result and wait for requireAC.
- Arbitrates among NUM_REQ requesters round-robin and returns a one-cycle requireAC pulse to the winner.
- Registers the winner's tag and data onto the CDB broadcast outputs, which the reservation stations and register file snoop.

---
 rtl/cdb_pkg.sv | 26 ++
 rtl/cdb_arbiter_rr_picker.sv | 47 ++++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the common-data-bus arbiter.
//   CDB_NUM_REQ / CDB_TAG_W / CDB_DATA_W : default geometry (unit 0 = memory unit)
//   NO_TAG                                : tag value meaning "no producer"
//   cdb_bus_t                             : broadcast bundle as snooped by the
//                                           reservation stations / register file
//   idxW()                                : index width for a requester count
package cdb_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_TAG_W   = 4;
  localparam int CDB_DATA_W  = 32;

  localparam logic [CDB_TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority first-one finder.
//   eligible : request vector after masking
//   rrPtr    : index that currently has highest priority
//   winOh    : one-hot winner (zero when nothing eligible)
//   winIdx   : winner index (zero when nothing eligible)
//   anyValid : at least one eligible bit
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rrPtr,
  output logic [N-1:0]  winOh,
  output logic [IW-1:0] winIdx,
  output logic          anyValid
);

  localparam int SW = IW + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [SW-1:0]  sum;

  // Rotate so that bit rrPtr lands on bit 0; doubling the vector makes the
  // wrap from N-1 back to 0 fall out of a plain right shift.
  assign dbl = {eligible, eligible} >> rrPtr;
  assign rot = dbl[N-1:0];

  // Lowest set bit of the rotated vector = distance from rrPtr to the winner.
  always_comb begin
    off      = '0;
    anyValid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off      = IW'(i);
        anyValid = 1'b1;
      end
    end
  end

  // Undo the rotation: (rrPtr + off) mod N without a divider.
  assign sum    = {1'b0, rrPtr} + {1'b0, off};
  assign winIdx = (sum >= SW'(N)) ? IW'(sum - SW'(N)) : sum[IW-1:0];
  assign winOh  = anyValid ? (N'(1) << winIdx) : '0;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: responder side of the common-data-bus handshake.
// Functional units raise requireCDB with a tag/result; one winner per cycle
// gets a single-cycle requireAC pulse and its tag/data is registered onto the
// CDB broadcast outputs.
//   clk, rst    : clock, asynchronous active-high reset
//   requireCDB  : per-unit request, held until that unit sees requireAC
//   reqTag      : per-unit tag,  unit i at [i*TAG_W  +: TAG_W]
//   reqData     : per-unit data, unit i at [i*DATA_W +: DATA_W]
//   requireAC   : one-hot acknowledge, one cycle long
//   cdbValid/cdbTag/cdbData : registered broadcast (tag/data hold when idle)
// Build option: define CDB_MEM_PRIO_EN to give unit 0 (memory unit) absolute
// priority whenever it is eligible; otherwise pure round-robin.
module cdb_arbiter import cdb_pkg::*; #(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        requireCDB,
  input  logic [NUM_REQ*TAG_W-1:0]  reqTag,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        requireAC,
  output logic                      cdbValid,
  output logic [TAG_W-1:0]          cdbTag,
  output logic [DATA_W-1:0]         cdbData
);

  localparam int IW = idxW(NUM_REQ);

  logic [NUM_REQ-1:0][TAG_W-1:0]  tagArr;
  logic [NUM_REQ-1:0][DATA_W-1:0] dataArr;

  logic [NUM_REQ-1:0] lastGrant, eligible, pickOh, winOh;
  logic [IW-1:0]      rrPtr, pickIdx, winIdx, nextPtr;
  logic               pickAny, winAny, updPtr;

  assign tagArr  = reqTag;
  assign dataArr = reqData;

  // The registered acknowledge doubles as the mask: on the edge where a unit
  // is looking at its ack it has not yet dropped requireCDB, so that stale
  // request must not win again.
  assign lastGrant = requireAC;
  assign eligible  = requireCDB & ~lastGrant;

  rr_picker #(.N(NUM_REQ), .IW(IW)) uPick (
    .eligible (eligible),
    .rrPtr    (rrPtr),
    .winOh    (pickOh),
    .winIdx   (pickIdx),
    .anyValid (pickAny)
  );

`ifdef CDB_MEM_PRIO_EN
  // Memory unit pre-empts the rotation and leaves rrPtr untouched so the
  // other units keep their place in line.
  always_comb begin
    if (eligible[0]) begin
      winOh  = NUM_REQ'(1);
      winIdx = '0;
      winAny = 1'b1;
      updPtr = 1'b0;
    end else begin
      winOh  = pickOh;
      winIdx = pickIdx;
      winAny = pickAny;
      updPtr = pickAny;
    end
  end
`else
  assign winOh  = pickOh;
  assign winIdx = pickIdx;
  assign winAny = pickAny;
  assign updPtr = pickAny;
`endif

  assign nextPtr = (winIdx == IW'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      requireAC <= '0;
      cdbValid  <= 1'b0;
      cdbTag    <= TAG_W'(NO_TAG);
      cdbData   <= '0;
      rrPtr     <= '0;
    end else begin
      requireAC <= winOh;
      cdbValid  <= winAny;
      if (winAny) begin
        cdbTag  <= tagArr[winIdx];
        cdbData <= dataArr[winIdx];
      end
      if (updPtr) rrPtr <= nextPtr;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   requireCDB;
  logic [15:0]  reqTag;
  logic [127:0] reqData;
  logic [3:0]   requireAC;
  logic         cdbValid;
  logic [3:0]   cdbTag;
  logic [31:0]  cdbData;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .requireCDB(requireCDB), .reqTag(reqTag),
    .reqData(reqData), .requireAC(requireAC), .cdbValid(cdbValid),
    .cdbTag(cdbTag), .cdbData(cdbData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ac;
    cdb_bus_t   bus;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monGot, monExp;
  logic [3:0]  tagTab [4];
  logic [31:0] dataTab [4];
  int          nCmp = 0;
  int          nFail = 0;
  logic        rndMode = 1'b0;
  logic [3:0]  nxt, ackSeen;
  int          waits [4];

  function automatic exp_t mkExp(input int u);
    exp_t e;
    e.ac       = 4'b0001 << u;
    e.bus.valid = 1'b1;
    e.bus.tag   = tagTab[u];
    e.bus.data  = dataTab[u];
    return e;
  endfunction

  function automatic int idxOf(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Scoreboard monitor: every cycle the DUT presents a grant is popped and
  // compared; in random mode only structural properties are checked.
  always @(negedge clk) begin
    if (!rst && (cdbValid || requireAC != 4'b0)) begin
      monGot.ac        = requireAC;
      monGot.bus.valid = cdbValid;
      monGot.bus.tag   = cdbTag;
      monGot.bus.data  = cdbData;
      if (rndMode) begin
        nCmp++;
        if (!$onehot(requireAC) || !cdbValid) begin
          nFail++;
          $display("FAIL grant_onehot: got ac=%b valid=%b, want one-hot ac with valid=1",
                   requireAC, cdbValid);
        end else begin
          monExp = mkExp(idxOf(requireAC));
          nCmp++;
          if (monGot !== monExp) begin
            nFail++;
            $display("FAIL rnd_bcast: got ac=%b tag=%0d data=%h, want tag=%0d data=%h",
                     requireAC, cdbTag, cdbData, monExp.bus.tag, monExp.bus.data);
          end
        end
      end else if (sbq.size() == 0) begin
        nCmp++;
        nFail++;
        $display("FAIL unexpected_grant: got ac=%b valid=%b tag=%0d, want no grant",
                 requireAC, cdbValid, cdbTag);
      end else begin
        monExp = sbq.pop_front();
        nCmp++;
        if (monGot !== monExp) begin
          nFail++;
          $display("FAIL bcast: got ac=%b valid=%b tag=%0d data=%h, want ac=%b valid=%b tag=%0d data=%h",
                   monGot.ac, monGot.bus.valid, monGot.bus.tag, monGot.bus.data,
                   monExp.ac, monExp.bus.valid, monExp.bus.tag, monExp.bus.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [40:0] got, input logic [40:0] exp);
    nCmp++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Apply a request vector, let one edge sample it, return just after it.
  task automatic drive(input logic [3:0] r);
    requireCDB = r;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic doReset(input string name);
    rst = 1'b1;
    requireCDB = 4'b0;
    #1;
    check(name, {requireAC, cdbValid, cdbTag, cdbData}, 41'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    tagTab[0] = 4'd3;  dataTab[0] = 32'hDEADBEEF;
    tagTab[1] = 4'd5;  dataTab[1] = 32'hA5A51111;
    tagTab[2] = 4'd9;  dataTab[2] = 32'h5A5A2222;
    tagTab[3] = 4'd0;  dataTab[3] = 32'h0F0F3333;   // NO_TAG passes through
    reqTag  = {tagTab[3], tagTab[2], tagTab[1], tagTab[0]};
    reqData = {dataTab[3], dataTab[2], dataTab[1], dataTab[0]};
    rst = 1'b1;
    requireCDB = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {requireAC, cdbValid, cdbTag, cdbData}, 41'b0);
    rst = 1'b0;

    // Single request from unit 0: one-cycle ack, then idle with tag/data held.
    sbq.push_back(mkExp(0));
    drive(4'b0001);
    drive(4'b0001);
    check("single_then_idle", {requireAC, cdbValid, cdbTag, cdbData},
          {4'b0000, 1'b0, 4'd3, 32'hDEADBEEF});
    drive(4'b0000);
    drive(4'b0000);

    // All four from rrPtr=0: grants 0,1,2,3 back to back.
    doReset("reset_before_all4");
    for (int u = 0; u < 4; u++) sbq.push_back(mkExp(u));
    drive(4'b1111);
    drive(4'b1111);
    drive(4'b1110);
    drive(4'b1100);
    drive(4'b1000);
    drive(4'b0000);
    check("all4_drained", {requireAC, cdbValid, 36'b0}, 41'b0);

    // Unit 2 overstays: masked edge gives nothing, next edge is a new grant.
    sbq.push_back(mkExp(2));
    sbq.push_back(mkExp(2));
    drive(4'b0100);
    drive(4'b0100);
    drive(4'b0100);
    drive(4'b0100);
    drive(4'b0000);
    drive(4'b0000);

    // Reset during a grant: pulse dropped, rrPtr back to 0 (unit 1 then wins
    // over unit 3).
    drive(4'b0100);
    check("pre_reset_grant", {37'b0, requireAC}, 41'b0100);
    doReset("reset_mid_grant");
    sbq.push_back(mkExp(1));
    sbq.push_back(mkExp(3));
    drive(4'b1010);
    drive(4'b1010);
    drive(4'b1000);
    drive(4'b0000);
    drive(4'b0000);

`ifdef CDB_MEM_PRIO_EN
    // Memory-unit priority: unit 0 wins whenever eligible.
    doReset("reset_before_prio");
    sbq.push_back(mkExp(0));
    sbq.push_back(mkExp(1));
    sbq.push_back(mkExp(2));
    sbq.push_back(mkExp(0));
    sbq.push_back(mkExp(3));
    sbq.push_back(mkExp(0));
    drive(4'b1111);
    drive(4'b1111);
    drive(4'b1110);
    drive(4'b1101);
    drive(4'b1001);
    drive(4'b1000);
    drive(4'b0001);
    drive(4'b0001);
    drive(4'b0000);
    drive(4'b0000);
`else
    // Random well-behaved requesters: wait bounded by NUM_REQ-1 grants.
    rndMode = 1'b1;
    ackSeen = 4'b0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      nxt = requireCDB;
      for (int i = 0; i < 4; i++) begin
        if (ackSeen[i]) begin
          nxt[i] = 1'b0;
          ackSeen[i] = 1'b0;
        end else if (requireCDB[i]) begin
          if (requireAC[i]) begin
            nCmp++;
            if (waits[i] > 3) begin
              nFail++;
              $display("FAIL starve: unit %0d waited %0d grants, limit 3", i, waits[i]);
            end
            ackSeen[i] = 1'b1;
          end else if (requireAC != 4'b0) begin
            waits[i]++;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          nxt[i] = 1'b1;
          waits[i] = 0;
        end
      end
      drive(nxt);
    end
    drive(4'b0000);
    drive(4'b0000);
    drive(4'b0000);
    rndMode = 1'b0;
`endif

    drive(4'b0000);
    check("scoreboard_empty", 41'(sbq.size()), 41'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
